// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch/commit bundle between the PC sequencer, branch logic and instruction memory
//
// Purpose: groups the sequencer's non-clock signals.
// Build option: PC_REDIRECT_CNT_EN adds the CNT_W parameter and the TAKEN_COUNT signal.
// Signals:
//    PC_INC        branch/jump offset from the offset adder (two's complement, 0 = no redirect)
//    BUSYWAIT      data-memory stall
//    IMEM_BUSYWAIT instruction memory still busy with the current read
//    PC            current instruction address
//    PC_PLUS4      PC + PC_STEP
//    IMEM_READ     instruction read request
//    INSTR_VALID   instruction at PC is stable
//    TAKEN_COUNT   committed redirects (PC_REDIRECT_CNT_EN only)
// Modports: master = sequencer side, slave = branch logic / memory side.
interface pc_sequencer_if
`ifdef PC_REDIRECT_CNT_EN
   #(parameter int CNT_W = 16)
`endif
   ;
   logic [31:0] PC_INC;
   logic        BUSYWAIT;
   logic        IMEM_BUSYWAIT;
   logic [31:0] PC;
   logic [31:0] PC_PLUS4;
   logic        IMEM_READ;
   logic        INSTR_VALID;
`ifdef PC_REDIRECT_CNT_EN
   logic [CNT_W-1:0] TAKEN_COUNT;
`endif

   modport master (
      input  PC_INC, BUSYWAIT, IMEM_BUSYWAIT,
`ifdef PC_REDIRECT_CNT_EN
      output TAKEN_COUNT,
`endif
      output PC, PC_PLUS4, IMEM_READ, INSTR_VALID
   );

   modport slave (
      output PC_INC, BUSYWAIT, IMEM_BUSYWAIT,
`ifdef PC_REDIRECT_CNT_EN
      input  TAKEN_COUNT,
`endif
      input  PC, PC_PLUS4, IMEM_READ, INSTR_VALID
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with fetch handshake and stall handling
//
// Purpose: holds PC, requests each instruction from instruction memory, and commits
//    PC <= PC + PC_STEP + PC_INC once per instruction, stalling on either busywait.
// Build option: PC_REDIRECT_CNT_EN adds a saturating counter of committed redirects
//    (PC_INC != 0) on bus.TAKEN_COUNT, CNT_W bits wide.
// Ports:
//    CLK    in  clock, all state updates on posedge
//    RESET  in  synchronous active-high reset
//    bus    pc_sequencer_if.master (PC_INC, BUSYWAIT, IMEM_BUSYWAIT in;
//           PC, PC_PLUS4, IMEM_READ, INSTR_VALID, TAKEN_COUNT out)
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
`ifdef PC_REDIRECT_CNT_EN
   ,
   parameter int          CNT_W    = 16
`endif
) (
   input  logic           CLK,
   input  logic           RESET,
   pc_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      S_HOLD  = 2'b00,
      S_FETCH = 2'b01,
      S_EXEC  = 2'b10
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        read_q, read_d;
   logic        valid_q, valid_d;
   logic        commit;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_HOLD;
         pc_q    <= RESET_PC;
         read_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         read_q  <= read_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      read_d  = read_q;
      valid_d = valid_q;
      commit  = 1'b0;
      case (state_q)
         S_HOLD: begin
            state_d = S_FETCH;
            read_d  = 1'b1;
            valid_d = 1'b0;
         end
         S_FETCH: begin
            // Data-memory BUSYWAIT is deliberately not looked at while fetching.
            read_d  = 1'b1;
            valid_d = 1'b0;
            if (!bus.IMEM_BUSYWAIT) begin
               state_d = S_EXEC;
               read_d  = 1'b0;
               valid_d = 1'b1;
            end
         end
         S_EXEC: begin
            read_d  = 1'b0;
            valid_d = 1'b1;
            if (!bus.BUSYWAIT) begin
               // PC_INC is only sampled here; modulo-2^32 wrap is intended.
               commit  = 1'b1;
               pc_d    = pc_q + PC_STEP + bus.PC_INC;
               state_d = S_FETCH;
               read_d  = 1'b1;
               valid_d = 1'b0;
            end
         end
         default: begin
            // Unused encoding: recover through S_HOLD without touching PC.
            state_d = S_HOLD;
            read_d  = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   assign bus.PC          = pc_q;
   assign bus.PC_PLUS4    = pc_q + PC_STEP;
   assign bus.IMEM_READ   = read_q;
   assign bus.INSTR_VALID = valid_q;

`ifdef PC_REDIRECT_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturates at all-ones rather than wrapping.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_q <= '0;
      end else if (commit && (bus.PC_INC != 32'd0) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign bus.TAKEN_COUNT = cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic CLK = 1'b0;
   logic RESET;
   logic rst_w;

   always #5 CLK = ~CLK;

`ifdef PC_REDIRECT_CNT_EN
   pc_sequencer_if #(.CNT_W(2)) bus ();
   pc_sequencer_if #(.CNT_W(2)) bus_w ();
`else
   pc_sequencer_if bus ();
   pc_sequencer_if bus_w ();
`endif

   pc_sequencer #(
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (32'd4)
`ifdef PC_REDIRECT_CNT_EN
      ,
      .CNT_W    (2)
`endif
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.master)
   );

   pc_sequencer #(
      .RESET_PC (32'hFFFF_FFFC),
      .PC_STEP  (32'd4)
`ifdef PC_REDIRECT_CNT_EN
      ,
      .CNT_W    (2)
`endif
   ) dut_w (
      .CLK   (CLK),
      .RESET (rst_w),
      .bus   (bus_w.master)
   );

   typedef struct {
      logic        rst;
      logic        imem_bw;
      logic        bw;
      logic [31:0] inc;
      logic [31:0] exp_pc;
      logic        exp_read;
      logic        exp_valid;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic r, input logic ib, input logic b, input logic [31:0] inc,
                      input logic [31:0] pc, input logic rd, input logic vl);
      vec_t v;
      v.rst = r; v.imem_bw = ib; v.bw = b; v.inc = inc;
      v.exp_pc = pc; v.exp_read = rd; v.exp_valid = vl;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // rst, imem_bw, bw, pc_inc, exp pc, exp read, exp valid
      add(1, 0, 0, 32'h0,         32'h00, 0, 0);
      add(1, 0, 0, 32'h0,         32'h00, 0, 0);
      add(0, 0, 0, 32'h0,         32'h00, 1, 0);
      add(0, 0, 0, 32'h0,         32'h00, 0, 1);
      add(0, 0, 0, 32'h0,         32'h04, 1, 0);
      add(0, 0, 0, 32'h0,         32'h04, 0, 1);
      add(0, 0, 0, 32'h0,         32'h08, 1, 0);
      add(0, 0, 0, 32'h0,         32'h08, 0, 1);
      add(0, 0, 0, 32'h10,        32'h1C, 1, 0);
      add(0, 0, 0, 32'hFFFF_FFFF, 32'h1C, 0, 1);
      add(0, 0, 0, 32'hFFFF_FFF0, 32'h10, 1, 0);
      add(0, 1, 0, 32'h100,       32'h10, 1, 0);
      add(0, 1, 0, 32'h100,       32'h10, 1, 0);
      add(0, 1, 0, 32'h100,       32'h10, 1, 0);
      add(0, 0, 0, 32'h100,       32'h10, 0, 1);
      add(0, 0, 1, 32'h40,        32'h10, 0, 1);
      add(0, 0, 1, 32'h80,        32'h10, 0, 1);
      add(0, 0, 0, 32'h0,         32'h14, 1, 0);
      add(0, 0, 1, 32'h0,         32'h14, 0, 1);
      add(0, 0, 0, 32'h0,         32'h18, 1, 0);
      add(0, 1, 0, 32'h0,         32'h18, 1, 0);
      add(1, 1, 1, 32'h0,         32'h00, 0, 0);
      add(0, 0, 0, 32'h0,         32'h00, 1, 0);

      rst_w = 1'b1;
      bus_w.IMEM_BUSYWAIT = 1'b0;
      bus_w.BUSYWAIT = 1'b0;
      bus_w.PC_INC = 32'h0;

      foreach (vecs[i]) begin
         RESET = vecs[i].rst;
         bus.IMEM_BUSYWAIT = vecs[i].imem_bw;
         bus.BUSYWAIT = vecs[i].bw;
         bus.PC_INC = vecs[i].inc;
         step();
         chk($sformatf("v%0d pc", i), bus.PC, vecs[i].exp_pc);
         chk($sformatf("v%0d pc_plus4", i), bus.PC_PLUS4, vecs[i].exp_pc + 32'd4);
         chk($sformatf("v%0d imem_read", i), {31'd0, bus.IMEM_READ}, {31'd0, vecs[i].exp_read});
         chk($sformatf("v%0d instr_valid", i), {31'd0, bus.INSTR_VALID}, {31'd0, vecs[i].exp_valid});
      end

      // Wrap-around from RESET_PC = 0xFFFF_FFFC and reset during a data stall.
      RESET = 1'b1;
      rst_w = 1'b1;
      step();
      chk("wrap reset pc", bus_w.PC, 32'hFFFF_FFFC);
      chk("wrap reset pc_plus4", bus_w.PC_PLUS4, 32'h0000_0000);
      rst_w = 1'b0;
      step();
      chk("wrap fetch read", {31'd0, bus_w.IMEM_READ}, 32'd1);
      step();
      chk("wrap exec valid", {31'd0, bus_w.INSTR_VALID}, 32'd1);
      step();
      chk("wrap commit pc", bus_w.PC, 32'h0000_0000);
      step();
      chk("wrap exec pc", bus_w.PC, 32'h0000_0000);
      bus_w.BUSYWAIT = 1'b1;
      bus_w.PC_INC = 32'h8;
      step();
      chk("stall pc held", bus_w.PC, 32'h0000_0000);
      chk("stall valid", {31'd0, bus_w.INSTR_VALID}, 32'd1);
      rst_w = 1'b1;
      step();
      chk("stall reset pc", bus_w.PC, 32'hFFFF_FFFC);
      chk("stall reset valid", {31'd0, bus_w.INSTR_VALID}, 32'd0);
      chk("stall reset read", {31'd0, bus_w.IMEM_READ}, 32'd0);
      rst_w = 1'b0;
      bus_w.BUSYWAIT = 1'b0;
      step();
      chk("after hold read", {31'd0, bus_w.IMEM_READ}, 32'd1);
      chk("after hold pc", bus_w.PC, 32'hFFFF_FFFC);

`ifdef PC_REDIRECT_CNT_EN
      begin
         logic [31:0] incs[7];
         incs = '{32'h8, 32'h0, 32'hC, 32'h4, 32'h0, 32'h10, 32'hFFFF_FFF8};
         RESET = 1'b1;
         bus.IMEM_BUSYWAIT = 1'b0;
         bus.BUSYWAIT = 1'b0;
         bus.PC_INC = 32'h0;
         step();
         chk("count reset", {30'd0, bus.TAKEN_COUNT}, 32'd0);
         RESET = 1'b0;
         step();
         for (int k = 0; k < 7; k++) begin
            bus.PC_INC = 32'h0;
            step();
            bus.PC_INC = incs[k];
            step();
            if (k == 2) chk("count mid", {30'd0, bus.TAKEN_COUNT}, 32'd2);
         end
         chk("count saturated", {30'd0, bus.TAKEN_COUNT}, 32'd3);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
